hazard_ctrl_mc: RTL and testbench

- Parametrised next-generation stall/flush controller for the 5-stage RiscY pipeline.
- Adds three things to the combinational stall unit:
  - a one-entry scoreboard for a multi-cycle functional unit (MUL/DIV) with a configurable latency;
  - a registered trap-deferral FSM that drains in-flight branches before releasing a syscall trap;
  - a memory-stall watchdog.
- Sits in ID. Drives the bubble/write enables of all pipeline registers and the PC.

---
 rtl/hazard_ctrl_mc.sv | 195 +++++++++++++++++++
 tb/tb_hazard_ctrl_mc.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_mc.sv
// Stall/flush controller for the 5-stage RiscY pipeline: combinational hazard priority,
// multi-cycle unit scoreboard, syscall trap-deferral FSM and memory-stall watchdog.
module hazard_ctrl_mc #(
  parameter int REG_AW = 5,
  parameter int MC_LAT = 4,
  parameter int CNT_W  = 3,
  parameter int MEM_TO = 255,
  parameter int TO_W   = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [REG_AW-1:0] ifid_rs,
  input  logic [REG_AW-1:0] ifid_rt,
  input  logic              ifid_use_rs,
  input  logic              ifid_use_rt,
  input  logic [REG_AW-1:0] idex_rd,
  input  logic              idex_memread,
  input  logic              idex_memWrite,
  input  logic              memRead,
  input  logic              memReady,
  input  logic              mc_start,
  input  logic [REG_AW-1:0] mc_rd,
  input  logic              Jump,
  input  logic              trap_in_ID,
  input  logic              IDEX_Branch,
  input  logic              EXMEM_Branch,
  input  logic              syscall,
  input  logic              int_trap,
  input  logic              flushPipeline,
  input  logic              PCSrc,
  output logic              bubble_ifid,
  output logic              bubble_idex,
  output logic              bubble_exmem,
  output logic              bubble_memwb,
  output logic              write_ifid,
  output logic              write_idex,
  output logic              write_exmem,
  output logic              write_memwb,
  output logic              write_pc,
  output logic              trap_waiting,
  output logic              mc_busy,
  output logic              mc_done,
  output logic              mem_timeout
);

  typedef enum logic [1:0] {T_IDLE, T_DRAIN, T_ISSUE} trap_state_t;

  localparam logic [CNT_W-1:0] MC_LOAD = CNT_W'(MC_LAT);
  localparam logic [TO_W-1:0]  TO_MAX  = TO_W'(MEM_TO);

  function automatic logic reg_match(input logic [REG_AW-1:0] rd,
                                     input logic [REG_AW-1:0] rs,
                                     input logic              used);
    return used && (rd != '0) && (rd == rs);
  endfunction

  function automatic logic [TO_W-1:0] sat_inc(input logic [TO_W-1:0] v);
    return (v == TO_MAX) ? v : v + TO_W'(1);
  endfunction

  trap_state_t       trap_state_q, trap_state_d;
  logic              trap_req;
  logic [CNT_W-1:0]  mc_cnt_q;
  logic              sb_vld_q;
  logic [REG_AW-1:0] mc_rd_q;
  logic              mc_done_q;
  logic [TO_W-1:0]   wd_cnt_q;
  logic [TO_W-1:0]   wd_inc;
  logic              to_q;
  logic              mc_kill, mc_accept;
  logic              struct_mem, load_use, mc_raw, mc_struct, hold;

  assign mc_busy     = (mc_cnt_q != '0);
  assign mc_done     = mc_done_q;
  assign mem_timeout = to_q;

  assign mc_kill   = int_trap | PCSrc;
  assign mc_accept = mc_start & ~mc_busy & memReady & ~mc_kill;

  assign struct_mem = memRead & idex_memWrite;
  assign load_use   = idex_memread & (reg_match(idex_rd, ifid_rs, ifid_use_rs) |
                                      reg_match(idex_rd, ifid_rt, ifid_use_rt));
  assign mc_raw     = sb_vld_q & (reg_match(mc_rd_q, ifid_rs, ifid_use_rs) |
                                  reg_match(mc_rd_q, ifid_rt, ifid_use_rt));
  // Back-to-back starts stall even on the completion cycle; the new op enters a cycle later.
  assign mc_struct  = mc_start & mc_busy;
  assign hold       = (trap_state_q == T_DRAIN) | struct_mem | load_use | mc_raw | mc_struct;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mc_cnt_q  <= '0;
      sb_vld_q  <= 1'b0;
      mc_done_q <= 1'b0;
    end else if (mc_kill) begin
      mc_cnt_q  <= '0;
      sb_vld_q  <= 1'b0;
      mc_done_q <= 1'b0;
    end else if (mc_accept) begin
      mc_cnt_q  <= MC_LOAD;
      sb_vld_q  <= 1'b1;
      mc_done_q <= 1'b0;
    end else if (mc_busy && memReady) begin
      mc_cnt_q  <= mc_cnt_q - CNT_W'(1);
      mc_done_q <= (mc_cnt_q == CNT_W'(1));
      if (mc_cnt_q == CNT_W'(1)) sb_vld_q <= 1'b0;
    end else begin
      mc_done_q <= 1'b0;
    end
  end

  // Destination tag is only meaningful while sb_vld_q is set, so it carries no reset.
  always_ff @(posedge clock) begin
    if (mc_accept) mc_rd_q <= mc_rd;
  end

  assign wd_inc = sat_inc(wd_cnt_q);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wd_cnt_q <= '0;
      to_q     <= 1'b0;
    end else if (memReady) begin
      wd_cnt_q <= '0;
    end else begin
      wd_cnt_q <= wd_inc;
      if (wd_inc == TO_MAX) to_q <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) trap_state_q <= T_IDLE;
    else        trap_state_q <= trap_state_d;
  end

  always_comb begin
    trap_state_d = trap_state_q;
    trap_req     = 1'b0;
    case (trap_state_q)
      T_IDLE: begin
        if (syscall && (IDEX_Branch || EXMEM_Branch)) trap_state_d = T_DRAIN;
        else                                          trap_req     = syscall;
      end
      T_DRAIN: begin
        if ((!IDEX_Branch && !EXMEM_Branch) || PCSrc) trap_state_d = T_ISSUE;
      end
      T_ISSUE: begin
        trap_req = 1'b1;
        if (memReady) trap_state_d = T_IDLE;
      end
      default: trap_state_d = T_IDLE;
    endcase
    if (int_trap || flushPipeline) trap_state_d = T_IDLE;
  end

  always_comb begin
    bubble_ifid  = 1'b0;
    bubble_idex  = 1'b0;
    bubble_exmem = 1'b0;
    bubble_memwb = 1'b0;
    write_ifid   = 1'b1;
    write_idex   = 1'b1;
    write_exmem  = 1'b1;
    write_memwb  = 1'b1;
    write_pc     = 1'b1;
    trap_waiting = trap_req;
    if (!memReady) begin
      write_ifid   = 1'b0;
      write_idex   = 1'b0;
      write_exmem  = 1'b0;
      write_memwb  = 1'b0;
      write_pc     = 1'b0;
      trap_waiting = 1'b0;
    end else if (hold) begin
      bubble_idex  = 1'b1;
      write_ifid   = 1'b0;
      write_pc     = 1'b0;
    end else if (Jump || trap_in_ID) begin
      bubble_ifid  = 1'b1;
    end
    if (int_trap) begin
      bubble_ifid  = 1'b1;
      bubble_idex  = 1'b1;
      bubble_exmem = 1'b1;
      bubble_memwb = 1'b1;
      write_pc     = 1'b1;
    end else if (PCSrc) begin
      bubble_ifid  = 1'b1;
      bubble_idex  = 1'b1;
      bubble_exmem = 1'b1;
      write_pc     = 1'b1;
    end
    if (flushPipeline) bubble_ifid = 1'b1;
  end

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Directed bench for hazard_ctrl_mc; observed outputs are packed as
// {bubbles[4], writes ifid/idex/exmem/memwb/pc, trap_waiting, mc_busy, mc_done, mem_timeout}.
module tb_hazard_ctrl_mc;

  logic       clock;
  logic       reset;
  logic [4:0] ifid_rs, ifid_rt, idex_rd, mc_rd;
  logic       ifid_use_rs, ifid_use_rt, idex_memread, idex_memWrite, memRead, memReady, mc_start;
  logic       Jump, trap_in_ID, IDEX_Branch, EXMEM_Branch, syscall, int_trap, flushPipeline, PCSrc;
  logic       bubble_ifid, bubble_idex, bubble_exmem, bubble_memwb;
  logic       write_ifid, write_idex, write_exmem, write_memwb, write_pc;
  logic       trap_waiting, mc_busy, mc_done, mem_timeout;
  logic [12:0] obs;
  logic [12:0] exp_v;
  int total;
  int bad;

  hazard_ctrl_mc dut (
    .clock(clock), .reset(reset),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_use_rs(ifid_use_rs), .ifid_use_rt(ifid_use_rt),
    .idex_rd(idex_rd), .idex_memread(idex_memread), .idex_memWrite(idex_memWrite),
    .memRead(memRead), .memReady(memReady), .mc_start(mc_start), .mc_rd(mc_rd),
    .Jump(Jump), .trap_in_ID(trap_in_ID), .IDEX_Branch(IDEX_Branch), .EXMEM_Branch(EXMEM_Branch),
    .syscall(syscall), .int_trap(int_trap), .flushPipeline(flushPipeline), .PCSrc(PCSrc),
    .bubble_ifid(bubble_ifid), .bubble_idex(bubble_idex), .bubble_exmem(bubble_exmem),
    .bubble_memwb(bubble_memwb), .write_ifid(write_ifid), .write_idex(write_idex),
    .write_exmem(write_exmem), .write_memwb(write_memwb), .write_pc(write_pc),
    .trap_waiting(trap_waiting), .mc_busy(mc_busy), .mc_done(mc_done), .mem_timeout(mem_timeout)
  );

  assign obs = {bubble_ifid, bubble_idex, bubble_exmem, bubble_memwb,
                write_ifid, write_idex, write_exmem, write_memwb, write_pc,
                trap_waiting, mc_busy, mc_done, mem_timeout};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic clear_inputs;
    ifid_rs = '0; ifid_rt = '0; idex_rd = '0; mc_rd = '0;
    ifid_use_rs = 0; ifid_use_rt = 0; idex_memread = 0; idex_memWrite = 0;
    memRead = 0; memReady = 1; mc_start = 0;
    Jump = 0; trap_in_ID = 0; IDEX_Branch = 0; EXMEM_Branch = 0;
    syscall = 0; int_trap = 0; flushPipeline = 0; PCSrc = 0;
  endtask

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    clear_inputs();
    #2;
    exp_v = 13'b0000_11111_0_0_0_0; total++;
    if (obs !== exp_v) begin bad++; $display("FAIL reset_state got=%b want=%b", obs, exp_v); end
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b1;
    step();
  endtask

  task automatic test_load_use;
    idex_memread = 1; idex_rd = 5; ifid_rs = 5; ifid_use_rs = 1;
    @(negedge clock);
    exp_v = 13'b0100_01110_0_0_0_0; total++;
    if (obs !== exp_v) begin bad++; $display("FAIL load_use_rs got=%b want=%b", obs, exp_v); end
    step();
    idex_rd = 0; ifid_rs = 0;
    @(negedge clock);
    exp_v = 13'b0000_11111_0_0_0_0; total++;
    if (obs !== exp_v) begin bad++; $display("FAIL load_use_x0 got=%b want=%b", obs, exp_v); end
    step();
    idex_rd = 3; ifid_rs = 5; ifid_rt = 3; ifid_use_rt = 1;
    @(negedge clock);
    exp_v = 13'b0100_01110_0_0_0_0; total++;
    if (obs !== exp_v) begin bad++; $display("FAIL load_use_rt got=%b want=%b", obs, exp_v); end
    ifid_use_rt = 0;
    #1;
    exp_v = 13'b0000_11111_0_0_0_0; total++;
    if (obs !== exp_v) begin bad++; $display("FAIL load_use_unused got=%b want=%b", obs, exp_v); end
    clear_inputs();
    step();
  endtask

  task automatic test_priority;
    Jump = 1;
    @(negedge clock);
    exp_v = 13'b1000_11111_0_0_0_0; total++;
    if (obs !== exp_v) begin bad++; $display("FAIL jump got=%b want=%b", obs, exp_v); end
    idex_memread = 1; idex_rd = 6; ifid_rs = 6; ifid_use_rs = 1;
    #1;
    exp_v = 13'b0100_01110_0_0_0_0; total++;
    if (obs !== exp_v) begin bad++; $display("FAIL stall_over_jump got=%b want=%b", obs, exp_v); end
    clear_inputs();
    step();
    trap_in_ID = 1;
    @(negedge clock);
    exp_v = 13'b1000_11111_0_0_0_0; total++;
    if (obs !== exp_v) begin bad++; $display("FAIL trap_in_id got=%b want=%b", obs, exp_v); end
    clear_inputs();
    memRead = 1; idex_memWrite = 1;
    #1;
    exp_v = 13'b0100_01110_0_0_0_0; total++;
    if (obs !== exp_v) begin bad++; $display("FAIL mem_struct got=%b want=%b", obs, exp_v); end
    memReady = 0;
    #1;
    exp_v = 13'b0000_00000_0_0_0_0; total++;
    if (obs !== exp_v) begin bad++; $display("FAIL mem_not_ready got=%b want=%b", obs, exp_v); end
    int_trap = 1;
    #1;
    exp_v = 13'b1111_00001_0_0_0_0; total++;
    if (obs !== exp_v) begin bad++; $display("FAIL int_trap_over_memready got=%b want=%b", obs, exp_v); end
    clear_inputs();
    flushPipeline = 1;
    #1;
    exp_v = 13'b1000_11111_0_0_0_0; total++;
    if (obs !== exp_v) begin bad++; $display("FAIL flush got=%b want=%b", obs, exp_v); end
    clear_inputs();
    step();
  endtask

  task automatic test_mc;
    mc_start = 1; mc_rd = 7;
    @(negedge clock);
    exp_v = 13'b0000_11111_0_0_0_0; total++;
    if (obs !== exp_v) begin bad++; $display("FAIL mc_accept_cycle got=%b want=%b", obs, exp_v); end
    step();
    mc_start = 0; ifid_rs = 7; ifid_use_rs = 1;
    @(negedge clock);
    exp_v = 13'b0100_01110_0_1_0_0; total++;
    if (obs !== exp_v) begin bad++; $display("FAIL mc_raw_rs got=%b want=%b", obs, exp_v); end
    step();
    ifid_rs = 8; ifid_rt = 7; ifid_use_rt = 0;
    @(negedge clock);
    exp_v = 13'b0000_11111_0_1_0_0; total++;
    if (obs !== exp_v) begin bad++; $display("FAIL mc_no_raw got=%b want=%b", obs, exp_v); end
    ifid_use_rt = 1;
    #1;
    exp_v = 13'b0100_01110_0_1_0_0; total++;
    if (obs !== exp_v) begin bad++; $display("FAIL mc_raw_rt got=%b want=%b", obs, exp_v); end
    step();
    ifid_use_rs = 0; ifid_use_rt = 0; mc_start = 1; mc_rd = 9;
    @(negedge clock);
    exp_v = 13'b0100_01110_0_1_0_0; total++;
    if (obs !== exp_v) begin bad++; $display("FAIL mc_struct got=%b want=%b", obs, exp_v); end
    step();
    @(negedge clock);
    exp_v = 13'b0100_01110_0_1_0_0; total++;
    if (obs !== exp_v) begin bad++; $display("FAIL mc_struct_last got=%b want=%b", obs, exp_v); end
    step();
    ifid_rs = 7; ifid_use_rs = 1;
    @(negedge clock);
    exp_v = 13'b0000_11111_0_0_1_0; total++;
    if (obs !== exp_v) begin bad++; $display("FAIL mc_done_release got=%b want=%b", obs, exp_v); end
    step();
    mc_start = 0;
    @(negedge clock);
    exp_v = 13'b0000_11111_0_1_0_0; total++;
    if (obs !== exp_v) begin bad++; $display("FAIL mc_second_busy got=%b want=%b", obs, exp_v); end
    ifid_rs = 9;
    #1;
    exp_v = 13'b0100_01110_0_1_0_0; total++;
    if (obs !== exp_v) begin bad++; $display("FAIL mc_second_raw got=%b want=%b", obs, exp_v); end
    ifid_use_rs = 0;
    step();
    step();
    memReady = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      exp_v = 13'b0000_00000_0_1_0_0; total++;
      if (obs !== exp_v) begin bad++; $display("FAIL mc_freeze%0d got=%b want=%b", i, obs, exp_v); end
      step();
    end
    memReady = 1;
    @(negedge clock);
    exp_v = 13'b0000_11111_0_1_0_0; total++;
    if (obs !== exp_v) begin bad++; $display("FAIL mc_resume_cnt2 got=%b want=%b", obs, exp_v); end
    step();
    @(negedge clock);
    exp_v = 13'b0000_11111_0_1_0_0; total++;
    if (obs !== exp_v) begin bad++; $display("FAIL mc_resume_cnt1 got=%b want=%b", obs, exp_v); end
    step();
    @(negedge clock);
    exp_v = 13'b0000_11111_0_0_1_0; total++;
    if (obs !== exp_v) begin bad++; $display("FAIL mc_done_delayed got=%b want=%b", obs, exp_v); end
    step();
    @(negedge clock);
    exp_v = 13'b0000_11111_0_0_0_0; total++;
    if (obs !== exp_v) begin bad++; $display("FAIL mc_done_pulse got=%b want=%b", obs, exp_v); end
    clear_inputs();
    step();
  endtask

  task automatic test_trap;
    syscall = 1;
    @(negedge clock);
    exp_v = 13'b0000_11111_1_0_0_0; total++;
    if (obs !== exp_v) begin bad++; $display("FAIL syscall_direct got=%b want=%b", obs, exp_v); end
    EXMEM_Branch = 1;
    #1;
    exp_v = 13'b0000_11111_0_0_0_0; total++;
    if (obs !== exp_v) begin bad++; $display("FAIL syscall_defer got=%b want=%b", obs, exp_v); end
    step();
    @(negedge clock);
    exp_v = 13'b0100_01110_0_0_0_0; total++;
    if (obs !== exp_v) begin bad++; $display("FAIL drain_hold got=%b want=%b", obs, exp_v); end
    step();
    EXMEM_Branch = 0; syscall = 0;
    @(negedge clock);
    exp_v = 13'b0100_01110_0_0_0_0; total++;
    if (obs !== exp_v) begin bad++; $display("FAIL drain_exit got=%b want=%b", obs, exp_v); end
    step();
    @(negedge clock);
    exp_v = 13'b0000_11111_1_0_0_0; total++;
    if (obs !== exp_v) begin bad++; $display("FAIL issue got=%b want=%b", obs, exp_v); end
    step();
    @(negedge clock);
    exp_v = 13'b0000_11111_0_0_0_0; total++;
    if (obs !== exp_v) begin bad++; $display("FAIL issue_once got=%b want=%b", obs, exp_v); end
    syscall = 1; IDEX_Branch = 1;
    step();
    syscall = 0; PCSrc = 1;
    @(negedge clock);
    exp_v = 13'b1110_01111_0_0_0_0; total++;
    if (obs !== exp_v) begin bad++; $display("FAIL drain_pcsrc got=%b want=%b", obs, exp_v); end
    step();
    PCSrc = 0; IDEX_Branch = 0; memReady = 0;
    @(negedge clock);
    exp_v = 13'b0000_00000_0_0_0_0; total++;
    if (obs !== exp_v) begin bad++; $display("FAIL issue_memstall got=%b want=%b", obs, exp_v); end
    step();
    memReady = 1;
    @(negedge clock);
    exp_v = 13'b0000_11111_1_0_0_0; total++;
    if (obs !== exp_v) begin bad++; $display("FAIL issue_held got=%b want=%b", obs, exp_v); end
    step();
    @(negedge clock);
    exp_v = 13'b0000_11111_0_0_0_0; total++;
    if (obs !== exp_v) begin bad++; $display("FAIL issue_idle got=%b want=%b", obs, exp_v); end
    clear_inputs();
    step();
  endtask

  task automatic test_int_trap;
    mc_start = 1; mc_rd = 4;
    step();
    mc_start = 0; syscall = 1; IDEX_Branch = 1;
    @(negedge clock);
    exp_v = 13'b0000_11111_0_1_0_0; total++;
    if (obs !== exp_v) begin bad++; $display("FAIL int_setup got=%b want=%b", obs, exp_v); end
    step();
    syscall = 0;
    @(negedge clock);
    exp_v = 13'b0100_01110_0_1_0_0; total++;
    if (obs !== exp_v) begin bad++; $display("FAIL int_drain_busy got=%b want=%b", obs, exp_v); end
    int_trap = 1;
    #1;
    exp_v = 13'b1111_01111_0_1_0_0; total++;
    if (obs !== exp_v) begin bad++; $display("FAIL int_trap_flush got=%b want=%b", obs, exp_v); end
    step();
    int_trap = 0; IDEX_Branch = 0;
    @(negedge clock);
    exp_v = 13'b0000_11111_0_0_0_0; total++;
    if (obs !== exp_v) begin bad++; $display("FAIL int_after got=%b want=%b", obs, exp_v); end
    for (int i = 0; i < 5; i++) begin
      step();
      @(negedge clock);
      total++;
      if (mc_done !== 1'b0) begin bad++; $display("FAIL int_no_done%0d got=%b want=0", i, mc_done); end
    end
    clear_inputs();
    step();
  endtask

  task automatic test_watchdog;
    memReady = 0;
    repeat (254) step();
    @(negedge clock);
    total++;
    if (mem_timeout !== 1'b0) begin bad++; $display("FAIL wd_254 got=%b want=0", mem_timeout); end
    step();
    @(negedge clock);
    total++;
    if (mem_timeout !== 1'b1) begin bad++; $display("FAIL wd_255 got=%b want=1", mem_timeout); end
    memReady = 1;
    step();
    @(negedge clock);
    exp_v = 13'b0000_11111_0_0_0_1; total++;
    if (obs !== exp_v) begin bad++; $display("FAIL wd_sticky got=%b want=%b", obs, exp_v); end
    mc_start = 1; mc_rd = 3;
    step();
    mc_start = 0; syscall = 1; EXMEM_Branch = 1;
    step();
    syscall = 0; EXMEM_Branch = 0;
    @(negedge clock);
    exp_v = 13'b0100_01110_0_1_0_1; total++;
    if (obs !== exp_v) begin bad++; $display("FAIL pre_reset got=%b want=%b", obs, exp_v); end
    #1;
    reset = 1'b0;
    #1;
    exp_v = 13'b0000_11111_0_0_0_0; total++;
    if (obs !== exp_v) begin bad++; $display("FAIL async_reset got=%b want=%b", obs, exp_v); end
    step();
    reset = 1'b1;
    step();
    @(negedge clock);
    exp_v = 13'b0000_11111_0_0_0_0; total++;
    if (obs !== exp_v) begin bad++; $display("FAIL post_reset got=%b want=%b", obs, exp_v); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_load_use();
    test_priority();
    test_mc();
    test_trap();
    test_int_trap();
    test_watchdog();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
